alb_mss_ibp_resp_mem: RTL and testbench

IBP target-side responder model for the MSS testbench. It terminates an IBP port from a bus initiator or a latency-injection stage, and services commands against an internal word-addressed memory. Supported traffic: single and burst reads/writes (incrementing or wrapping), an exclusive-access monitor, and out-of-range error responses. One transaction is outstanding at a time.

---
 rtl/alb_mss_ibp_resp_pkg.sv | 25 ++
 rtl/alb_mss_ibp_resp_mem_if.sv | 52 +++++
 rtl/alb_mss_ibp_resp_ram.sv | 27 ++
 rtl/alb_mss_ibp_resp_mem.sv | 157 +++++++++++++++
 tb/tb_alb_mss_ibp_resp_mem.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alb_mss_ibp_resp_pkg.sv
// Shared types and address helpers for the IBP responder memory model.
// Addresses are widened to 64 bits so the helpers serve any command address width.
package alb_mss_ibp_resp_pkg;

   typedef enum logic [1:0] {IDLE, RD, WR, WRESP} state_t;

   // Wrapping applies only to power-of-two beat counts; anything else increments.
   function automatic logic [63:0] next_beat_addr(input logic [63:0] addr,
                                                  input logic [2:0]  size,
                                                  input logic [3:0]  burst,
                                                  input logic        wrap);
      logic [63:0] inc;
      logic [63:0] win;
      inc = addr + (64'd1 << size);
      win = ({60'd0, burst} + 64'd1) << size;
      if (wrap && (burst == 4'd1 || burst == 4'd3 || burst == 4'd7 || burst == 4'd15))
         return (addr & ~(win - 64'd1)) | (inc & (win - 64'd1));
      return inc;
   endfunction

   function automatic logic in_range(input logic [63:0] addr, input int unsigned top);
      return (addr >> top) == 64'd0;
   endfunction

endpackage

// File: rtl/alb_mss_ibp_resp_mem_if.sv
// IBP command / read / write channel bundle between an initiator and the responder.
interface alb_mss_ibp_resp_mem_if #(
   parameter int a_w = 32,
   parameter int d_w = 32,
   parameter int u_w = 1
);
   logic             ibp_cmd_valid;
   logic             ibp_cmd_accept;
   logic             ibp_cmd_read;
   logic [a_w-1:0]   ibp_cmd_addr;
   logic             ibp_cmd_wrap;
   logic [2:0]       ibp_cmd_data_size;
   logic [3:0]       ibp_cmd_burst_size;
   logic [1:0]       ibp_cmd_prot;
   logic [3:0]       ibp_cmd_cache;
   logic             ibp_cmd_lock;
   logic [u_w-1:0]   ibp_cmd_user;
   logic             ibp_cmd_excl;
   logic             ibp_rd_valid;
   logic             ibp_rd_accept;
   logic [d_w-1:0]   ibp_rd_data;
   logic             ibp_rd_last;
   logic             ibp_err_rd;
   logic             ibp_rd_excl_ok;
   logic             ibp_wr_valid;
   logic             ibp_wr_accept;
   logic [d_w-1:0]   ibp_wr_data;
   logic [d_w/8-1:0] ibp_wr_mask;
   logic             ibp_wr_last;
   logic             ibp_wr_done;
   logic             ibp_wr_excl_done;
   logic             ibp_err_wr;
   logic             ibp_wr_resp_accept;

   modport slave (
      input  ibp_cmd_valid, ibp_cmd_read, ibp_cmd_addr, ibp_cmd_wrap, ibp_cmd_data_size,
             ibp_cmd_burst_size, ibp_cmd_prot, ibp_cmd_cache, ibp_cmd_lock, ibp_cmd_user,
             ibp_cmd_excl, ibp_rd_accept, ibp_wr_valid, ibp_wr_data, ibp_wr_mask,
             ibp_wr_last, ibp_wr_resp_accept,
      output ibp_cmd_accept, ibp_rd_valid, ibp_rd_data, ibp_rd_last, ibp_err_rd,
             ibp_rd_excl_ok, ibp_wr_accept, ibp_wr_done, ibp_wr_excl_done, ibp_err_wr
   );

   modport master (
      output ibp_cmd_valid, ibp_cmd_read, ibp_cmd_addr, ibp_cmd_wrap, ibp_cmd_data_size,
             ibp_cmd_burst_size, ibp_cmd_prot, ibp_cmd_cache, ibp_cmd_lock, ibp_cmd_user,
             ibp_cmd_excl, ibp_rd_accept, ibp_wr_valid, ibp_wr_data, ibp_wr_mask,
             ibp_wr_last, ibp_wr_resp_accept,
      input  ibp_cmd_accept, ibp_rd_valid, ibp_rd_data, ibp_rd_last, ibp_err_rd,
             ibp_rd_excl_ok, ibp_wr_accept, ibp_wr_done, ibp_wr_excl_done, ibp_err_wr
   );
endinterface

// File: rtl/alb_mss_ibp_resp_ram.sv
// Single-port synchronous RAM with byte-masked write and registered read data.
module alb_mss_ibp_resp_ram #(
   parameter int d_w = 32,
   parameter int aw  = 10
) (
   input  logic             clk,
   input  logic             en,
   input  logic             we,
   input  logic [aw-1:0]    addr,
   input  logic [d_w-1:0]   wdata,
   input  logic [d_w/8-1:0] mask,
   output logic [d_w-1:0]   rdata
);
   logic [d_w-1:0] mem [2**aw];

   // Read data only changes on a read, so it stays stable while a beat stalls.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int b = 0; b < d_w/8; b++)
               if (mask[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
         end else begin
            rdata <= mem[addr];
         end
      end
   end
endmodule

// File: rtl/alb_mss_ibp_resp_mem.sv
// IBP target responder: services one burst at a time against an internal memory,
// with an exclusive-access monitor and whole-command out-of-range errors.
module alb_mss_ibp_resp_mem
   import alb_mss_ibp_resp_pkg::*;
#(
   parameter int a_w    = 32,
   parameter int d_w    = 32,
   parameter int mem_aw = 10,
   parameter int u_w    = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clk_en,
   alb_mss_ibp_resp_mem_if.slave ibp
);
   localparam int BL  = $clog2(d_w/8);
   localparam int TOP = mem_aw + BL;

   state_t            state;
   logic [a_w-1:0]    addr_q;
   logic [2:0]        size_q;
   logic [3:0]        burst_q;
   logic              wrap_q, excl_q, err_q, pass_q;
   logic [4:0]        beats_q;
   logic              vld_q, fetch_q;
   logic              resv_vld;
   logic [mem_aw-1:0] resv_word;
   logic              done_q, excl_done_q, err_wr_q;

   logic [63:0]       cmd64, addr64, next64;
   logic [mem_aw-1:0] cmd_word, cur_word;
   logic              cmd_ok, cmd_acc, cmd_fire, rd_fire, wr_fire;
   logic              ram_en, ram_we;
   logic [mem_aw-1:0] ram_addr;
   logic [d_w-1:0]    ram_rdata;
   logic              unused_bits;

   always_comb begin
      cmd64 = '0;
      cmd64[a_w-1:0] = ibp.ibp_cmd_addr;
      addr64 = '0;
      addr64[a_w-1:0] = addr_q;
   end

   assign next64   = next_beat_addr(addr64, size_q, burst_q, wrap_q);
   assign cmd_word = cmd64[TOP-1:BL];
   assign cur_word = addr64[TOP-1:BL];
   assign cmd_ok   = in_range(cmd64, TOP);

   assign cmd_acc  = clk_en && !rst && state == IDLE;
   assign cmd_fire = cmd_acc && ibp.ibp_cmd_valid;
   assign rd_fire  = clk_en && vld_q && ibp.ibp_rd_accept;
   assign wr_fire  = clk_en && state == WR && ibp.ibp_wr_valid;

   assign ibp.ibp_cmd_accept   = cmd_acc;
   assign ibp.ibp_wr_accept    = clk_en && state == WR;
   assign ibp.ibp_rd_valid     = vld_q && !err_q;
   assign ibp.ibp_err_rd       = vld_q && err_q;
   assign ibp.ibp_rd_last      = vld_q && beats_q == 5'd1;
   assign ibp.ibp_rd_excl_ok   = vld_q && !err_q && excl_q;
   assign ibp.ibp_rd_data      = (vld_q && !err_q) ? ram_rdata : '0;
   assign ibp.ibp_wr_done      = done_q;
   assign ibp.ibp_wr_excl_done = excl_done_q;
   assign ibp.ibp_err_wr       = err_wr_q;

   assign unused_bits = ^{next64, ibp.ibp_cmd_prot, ibp.ibp_cmd_cache,
                          ibp.ibp_cmd_lock, ibp.ibp_cmd_user};

   always_comb begin
      ram_en   = 1'b0;
      ram_we   = 1'b0;
      ram_addr = cur_word;
      if (cmd_fire && ibp.ibp_cmd_read) begin
         ram_en   = 1'b1;
         ram_addr = cmd_word;
      end else if (clk_en && state == RD && fetch_q) begin
         ram_en = 1'b1;
      end else if (wr_fire && !err_q && (!excl_q || pass_q)) begin
         ram_en = 1'b1;
         ram_we = 1'b1;
      end
   end

   alb_mss_ibp_resp_ram #(.d_w(d_w), .aw(mem_aw)) u_ram (
      .clk   (clk),
      .en    (ram_en),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ibp.ibp_wr_data),
      .mask  (ibp.ibp_wr_mask),
      .rdata (ram_rdata)
   );

   // Command context and beat walker.
   always_ff @(posedge clk) begin
      if (cmd_fire) begin
         addr_q  <= ibp.ibp_cmd_addr;
         size_q  <= ibp.ibp_cmd_data_size;
         burst_q <= ibp.ibp_cmd_burst_size;
         wrap_q  <= ibp.ibp_cmd_wrap;
         beats_q <= {1'b0, ibp.ibp_cmd_burst_size} + 5'd1;
         excl_q  <= ibp.ibp_cmd_excl;
         err_q   <= !cmd_ok;
         pass_q  <= ibp.ibp_cmd_excl && resv_vld && cmd_ok && cmd_word == resv_word;
         if (ibp.ibp_cmd_read && ibp.ibp_cmd_excl && cmd_ok) resv_word <= cmd_word;
      end else if (rd_fire || wr_fire) begin
         addr_q  <= next64[a_w-1:0];
         beats_q <= beats_q - 5'd1;
      end
   end

   // Control FSM and registered response flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         vld_q       <= 1'b0;
         fetch_q     <= 1'b0;
         resv_vld    <= 1'b0;
         done_q      <= 1'b0;
         excl_done_q <= 1'b0;
         err_wr_q    <= 1'b0;
      end else if (clk_en) begin
         case (state)
            IDLE: if (ibp.ibp_cmd_valid) begin
               state <= ibp.ibp_cmd_read ? RD : WR;
               vld_q <= ibp.ibp_cmd_read;
               if (!ibp.ibp_cmd_read &&
                   (ibp.ibp_cmd_excl || (cmd_ok && cmd_word == resv_word)))
                  resv_vld <= 1'b0;
               else if (ibp.ibp_cmd_read && ibp.ibp_cmd_excl && cmd_ok)
                  resv_vld <= 1'b1;
            end
            RD: if (fetch_q) begin
               vld_q   <= 1'b1;
               fetch_q <= 1'b0;
            end else if (vld_q && ibp.ibp_rd_accept) begin
               vld_q <= 1'b0;
               if (beats_q == 5'd1) state <= IDLE;
               else fetch_q <= 1'b1;
            end
            WR: if (ibp.ibp_wr_valid && ibp.ibp_wr_last) begin
               state       <= WRESP;
               err_wr_q    <= err_q;
               excl_done_q <= !err_q && excl_q && pass_q;
               done_q      <= !err_q && !(excl_q && pass_q);
            end
            WRESP: if (ibp.ibp_wr_resp_accept) begin
               state       <= IDLE;
               done_q      <= 1'b0;
               excl_done_q <= 1'b0;
               err_wr_q    <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alb_mss_ibp_resp_mem.sv
// Self-checking bench for alb_mss_ibp_resp_mem: table of transactions with a
// scoreboard of expected beats/responses, plus stall, clk_en and reset sequences.
module tb_alb_mss_ibp_resp_mem;
   localparam int A_W = 32, D_W = 32, MEM_AW = 10, U_W = 1;
   localparam int R_DONE = 0, R_EXCL = 1, R_ERR = 2;

   logic clk = 1'b0;
   logic rst;
   logic clk_en;
   always #5 clk = ~clk;

   alb_mss_ibp_resp_mem_if #(.a_w(A_W), .d_w(D_W), .u_w(U_W)) ibp();

   alb_mss_ibp_resp_mem #(.a_w(A_W), .d_w(D_W), .mem_aw(MEM_AW), .u_w(U_W)) dut (
      .clk    (clk),
      .rst    (rst),
      .clk_en (clk_en),
      .ibp    (ibp.slave)
   );

   typedef struct {
      logic             rd;
      logic [31:0]      addr;
      logic [3:0]       burst;
      logic             wrap;
      logic             excl;
      logic [3:0]       mask;
      logic [31:0]      wdata;
      int               resp;
      logic             err;
      logic [3:0][31:0] d;
   } vec_t;

   typedef struct packed {
      logic [31:0] data;
      logic        last;
      logic        err;
      logic        xok;
   } beat_t;

   int    checks = 0;
   int    failures = 0;
   beat_t rd_q[$];
   int    resp_q[$];
   vec_t  vecs[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic vec_t mkw(input logic [31:0] addr, input logic [3:0] burst,
                                input logic excl, input logic [3:0] mask,
                                input logic [31:0] wdata, input int resp);
      vec_t v;
      v.rd = 1'b0; v.addr = addr; v.burst = burst; v.wrap = 1'b0; v.excl = excl;
      v.mask = mask; v.wdata = wdata; v.resp = resp; v.err = (resp == R_ERR); v.d = '0;
      return v;
   endfunction

   function automatic vec_t mkr(input logic [31:0] addr, input logic [3:0] burst,
                                input logic wrap, input logic excl, input logic err,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [31:0] d2, input logic [31:0] d3);
      vec_t v;
      v.rd = 1'b1; v.addr = addr; v.burst = burst; v.wrap = wrap; v.excl = excl;
      v.mask = 4'h0; v.wdata = '0; v.resp = R_DONE; v.err = err; v.d = {d3, d2, d1, d0};
      return v;
   endfunction

   task automatic send_cmd(input logic rd, input logic [31:0] addr, input logic [3:0] burst,
                           input logic wrap, input logic excl);
      int n = 0;
      ibp.ibp_cmd_read       = rd;
      ibp.ibp_cmd_addr       = addr;
      ibp.ibp_cmd_burst_size = burst;
      ibp.ibp_cmd_wrap       = wrap;
      ibp.ibp_cmd_excl       = excl;
      ibp.ibp_cmd_data_size  = 3'd2;
      ibp.ibp_cmd_valid      = 1'b1;
      @(negedge clk);
      while (!ibp.ibp_cmd_accept && n < 50) begin @(negedge clk); n++; end
      check("cmd_accept", 64'(ibp.ibp_cmd_accept), 64'd1);
      @(posedge clk); #1;
      ibp.ibp_cmd_valid = 1'b0;
   endtask

   task automatic do_read(input vec_t v);
      beat_t e;
      for (int i = 0; i <= int'(v.burst); i++) begin
         e.data = v.err ? 32'd0 : v.d[i];
         e.last = (i == int'(v.burst));
         e.err  = v.err;
         e.xok  = v.excl && !v.err;
         rd_q.push_back(e);
      end
      send_cmd(1'b1, v.addr, v.burst, v.wrap, v.excl);
      for (int i = 0; i <= int'(v.burst); i++) begin
         int n = 0;
         @(negedge clk);
         if (i == 0) check("rd_first_latency", 64'(ibp.ibp_rd_valid | ibp.ibp_err_rd), 64'd1);
         while (!(ibp.ibp_rd_valid || ibp.ibp_err_rd) && n < 20) begin @(negedge clk); n++; end
         if (rd_q.size() == 0) begin
            check("rd_queue_empty", 64'd1, 64'd0);
         end else begin
            e = rd_q.pop_front();
            check("rd_data",    64'(ibp.ibp_rd_data),    64'(e.data));
            check("rd_last",    64'(ibp.ibp_rd_last),    64'(e.last));
            check("err_rd",     64'(ibp.ibp_err_rd),     64'(e.err));
            check("rd_valid",   64'(ibp.ibp_rd_valid),   64'(!e.err));
            check("rd_excl_ok", 64'(ibp.ibp_rd_excl_ok), 64'(e.xok));
         end
         ibp.ibp_rd_accept = 1'b1;
         @(posedge clk); #1;
         ibp.ibp_rd_accept = 1'b0;
         if (i < int'(v.burst)) begin
            @(negedge clk);
            check("rd_gap", 64'(ibp.ibp_rd_valid | ibp.ibp_err_rd), 64'd0);
         end
      end
   endtask

   task automatic do_write(input vec_t v, input int nb);
      int n = 0;
      int r;
      resp_q.push_back(v.resp);
      send_cmd(1'b0, v.addr, v.burst, 1'b0, v.excl);
      for (int i = 0; i < nb; i++) begin
         ibp.ibp_wr_data  = v.wdata + 32'(i);
         ibp.ibp_wr_mask  = v.mask;
         ibp.ibp_wr_last  = (i == nb - 1);
         ibp.ibp_wr_valid = 1'b1;
         n = 0;
         @(negedge clk);
         while (!ibp.ibp_wr_accept && n < 20) begin @(negedge clk); n++; end
         check("wr_accept", 64'(ibp.ibp_wr_accept), 64'd1);
         @(posedge clk); #1;
         ibp.ibp_wr_valid = 1'b0;
         ibp.ibp_wr_last  = 1'b0;
      end
      n = 0;
      @(negedge clk);
      while (!(ibp.ibp_wr_done || ibp.ibp_wr_excl_done || ibp.ibp_err_wr) && n < 20) begin
         @(negedge clk); n++;
      end
      r = resp_q.pop_front();
      check("wr_done",      64'(ibp.ibp_wr_done),      64'(r == R_DONE));
      check("wr_excl_done", 64'(ibp.ibp_wr_excl_done), 64'(r == R_EXCL));
      check("err_wr",       64'(ibp.ibp_err_wr),       64'(r == R_ERR));
      ibp.ibp_wr_resp_accept = 1'b1;
      @(posedge clk); #1;
      ibp.ibp_wr_resp_accept = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_cmd_accept"}, 64'(ibp.ibp_cmd_accept), 64'd0);
      check({tag, "_rd_valid"},   64'(ibp.ibp_rd_valid),   64'd0);
      check({tag, "_rd_data"},    64'(ibp.ibp_rd_data),    64'd0);
      check({tag, "_rd_last"},    64'(ibp.ibp_rd_last),    64'd0);
      check({tag, "_err_rd"},     64'(ibp.ibp_err_rd),     64'd0);
      check({tag, "_excl_ok"},    64'(ibp.ibp_rd_excl_ok), 64'd0);
      check({tag, "_wr_accept"},  64'(ibp.ibp_wr_accept),  64'd0);
      check({tag, "_wr_resp"},    64'({ibp.ibp_wr_done, ibp.ibp_wr_excl_done, ibp.ibp_err_wr}), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vc;
      rst = 1'b1;
      clk_en = 1'b1;
      ibp.ibp_cmd_valid = 1'b0;      ibp.ibp_cmd_read = 1'b0;   ibp.ibp_cmd_addr = '0;
      ibp.ibp_cmd_wrap = 1'b0;       ibp.ibp_cmd_data_size = 3'd2;
      ibp.ibp_cmd_burst_size = 4'd0; ibp.ibp_cmd_prot = 2'd0;   ibp.ibp_cmd_cache = 4'd0;
      ibp.ibp_cmd_lock = 1'b0;       ibp.ibp_cmd_user = '0;     ibp.ibp_cmd_excl = 1'b0;
      ibp.ibp_rd_accept = 1'b0;      ibp.ibp_wr_valid = 1'b0;   ibp.ibp_wr_data = '0;
      ibp.ibp_wr_mask = '0;          ibp.ibp_wr_last = 1'b0;    ibp.ibp_wr_resp_accept = 1'b0;

      vecs.push_back(mkw(32'h40,  4'd0, 1'b0, 4'hF, 32'hDEADBEEF, R_DONE));
      vecs.push_back(mkr(32'h40,  4'd0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 0, 0, 0));
      vecs.push_back(mkw(32'h100, 4'd3, 1'b0, 4'hF, 32'd1, R_DONE));
      vecs.push_back(mkr(32'h108, 4'd3, 1'b1, 1'b0, 1'b0, 32'd3, 32'd4, 32'd1, 32'd2));
      vecs.push_back(mkr(32'h100, 4'd3, 1'b0, 1'b0, 1'b0, 32'd1, 32'd2, 32'd3, 32'd4));
      vecs.push_back(mkr(32'h104, 4'd1, 1'b1, 1'b0, 1'b0, 32'd2, 32'd1, 0, 0));
      vecs.push_back(mkw(32'h80,  4'd0, 1'b0, 4'hF, 32'hFFFFFFFF, R_DONE));
      vecs.push_back(mkw(32'h80,  4'd0, 1'b0, 4'h3, 32'hAAAA5555, R_DONE));
      vecs.push_back(mkr(32'h80,  4'd0, 1'b0, 1'b0, 1'b0, 32'hFFFF5555, 0, 0, 0));
      vecs.push_back(mkw(32'h200, 4'd0, 1'b0, 4'hF, 32'h11111111, R_DONE));
      vecs.push_back(mkr(32'h200, 4'd0, 1'b0, 1'b1, 1'b0, 32'h11111111, 0, 0, 0));
      vecs.push_back(mkw(32'h200, 4'd0, 1'b1, 4'hF, 32'h22222222, R_EXCL));
      vecs.push_back(mkr(32'h200, 4'd0, 1'b0, 1'b0, 1'b0, 32'h22222222, 0, 0, 0));
      vecs.push_back(mkw(32'h200, 4'd0, 1'b1, 4'hF, 32'h33333333, R_DONE));
      vecs.push_back(mkr(32'h200, 4'd0, 1'b0, 1'b0, 1'b0, 32'h22222222, 0, 0, 0));
      vecs.push_back(mkw(32'h300, 4'd0, 1'b0, 4'hF, 32'h5, R_DONE));
      vecs.push_back(mkr(32'h300, 4'd0, 1'b0, 1'b1, 1'b0, 32'h5, 0, 0, 0));
      vecs.push_back(mkw(32'h300, 4'd0, 1'b0, 4'hF, 32'h6, R_DONE));
      vecs.push_back(mkw(32'h300, 4'd0, 1'b1, 4'hF, 32'h7, R_DONE));
      vecs.push_back(mkr(32'h300, 4'd0, 1'b0, 1'b0, 1'b0, 32'h6, 0, 0, 0));
      vecs.push_back(mkr(32'h1000, 4'd1, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0));
      vecs.push_back(mkw(32'h1000, 4'd0, 1'b0, 4'hF, 32'h99, R_ERR));
      vecs.push_back(mkw(32'h1000, 4'd0, 1'b1, 4'hF, 32'h99, R_ERR));

      // Reset state, then release.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      @(negedge clk);
      check("post_reset_cmd_accept", 64'(ibp.ibp_cmd_accept), 64'd1);
      @(posedge clk); #1;

      foreach (vecs[k]) begin
         if (vecs[k].rd) do_read(vecs[k]);
         else            do_write(vecs[k], int'(vecs[k].burst) + 1);
      end

      // Early wr_last ends a 4-beat write after two beats.
      vc = mkw(32'h180, 4'd3, 1'b0, 4'hF, 32'd9, R_DONE);
      do_write(vc, 2);
      do_read(mkr(32'h180, 4'd1, 1'b0, 1'b0, 1'b0, 32'd9, 32'd10, 0, 0));

      // Stall, clk_en freeze and reset in the middle of a read burst.
      send_cmd(1'b1, 32'h100, 4'd3, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("stall_valid", 64'(ibp.ibp_rd_valid), 64'd1);
         check("stall_data",  64'(ibp.ibp_rd_data),  64'd1);
      end
      clk_en = 1'b0;
      ibp.ibp_rd_accept = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("ce_valid", 64'(ibp.ibp_rd_valid), 64'd1);
         check("ce_data",  64'(ibp.ibp_rd_data),  64'd1);
      end
      clk_en = 1'b1;
      @(posedge clk); #1;
      ibp.ibp_rd_accept = 1'b0;
      @(negedge clk);
      check("ce_gap", 64'(ibp.ibp_rd_valid), 64'd0);
      @(negedge clk);
      check("beat2_data", 64'(ibp.ibp_rd_data), 64'd2);
      ibp.ibp_rd_accept = 1'b1;
      @(posedge clk); #1;
      ibp.ibp_rd_accept = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("beat3_valid", 64'(ibp.ibp_rd_valid), 64'd1);
      rst = 1'b1;
      #1;
      check_all_zero("midrst");
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_release_cmd_accept", 64'(ibp.ibp_cmd_accept), 64'd1);
      clk_en = 1'b0;
      #1;
      check("ce_off_cmd_accept", 64'(ibp.ibp_cmd_accept), 64'd0);
      clk_en = 1'b1;
      @(posedge clk); #1;
      do_read(vecs[1]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
